riscv_hwloop_regs_track: RTL and testbench

- Hardware-loop register bank directly upstream of the hwloop controller. It holds the per-loop start address, end address and iteration counter.
- It tracks decrement requests that are in flight between IF and ID, and commits each decrement when the end-of-loop instruction leaves ID.
- It supplies the controller's start/end/counter inputs and its in-flight decrement flags. It consumes the controller's per-loop decrement request.

---
 rtl/riscv_hwloop_pkg.sv | 17 +
 rtl/riscv_hwloop_lane.sv | 96 +++++++++
 rtl/riscv_hwloop_regs_track.sv | 96 +++++++++
 tb/tb_riscv_hwloop_regs_track.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/riscv_hwloop_pkg.sv
// Shared types and constants for the hardware-loop register bank.
package riscv_hwloop_pkg;

    localparam int unsigned HWLP_N_REGS_DEFAULT = 2;
    localparam int unsigned HWLP_ADDR_W         = 32;

    typedef logic [HWLP_ADDR_W-1:0] hwlp_addr_t;

    // One loop's architectural state as seen by the controller.
    // The counter is always presented zero-extended to the full width.
    typedef struct packed {
        hwlp_addr_t start_addr;
        hwlp_addr_t end_addr;
        hwlp_addr_t counter;
    } hwlp_regs_t;

endpackage

// File: rtl/riscv_hwloop_lane.sv
// A single hardware loop: start/end/counter registers, the flag marking an
// end-of-loop decrement in flight between IF and ID, and its commit logic.
// Optional macro RISCV_HWLP_PERF_EN exposes a per-lane commit pulse.
module riscv_hwloop_lane
    import riscv_hwloop_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  hwlp_addr_t start_data_i,
    input  hwlp_addr_t end_data_i,
    input  hwlp_addr_t cnt_data_i,
    input  logic       start_we_i,
    input  logic       end_we_i,
    input  logic       cnt_we_i,
    input  logic       dec_cnt_i,
    input  logic       if_valid_i,
    input  logic       id_valid_i,
    input  logic       flush_i,
    output hwlp_regs_t regs_o,
    output logic       dec_id_o,
    output logic       active_o
`ifdef RISCV_HWLP_PERF_EN
    ,
    output logic       commit_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    hwlp_addr_t       start_q, start_d;
    hwlp_addr_t       end_q, end_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dec_id_q, dec_id_d;
    logic             commit;

    // Next-state: register writes, decrement commit, in-flight flag tracking.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        start_d  = start_q;
        end_d    = end_q;
        cnt_d    = cnt_q;
        dec_id_d = dec_id_q;
        commit   = id_valid_i && dec_id_q && !flush_i;

        if (start_we_i) start_d = start_data_i;
        if (end_we_i)   end_d   = end_data_i;

        // A counter write beats a commit; a commit on zero saturates.
        if (cnt_we_i) begin
            cnt_d = cnt_data_i[CNT_W-1:0];
        end else if (commit && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        // A fresh end-of-loop fetch entering ID wins over the old one leaving.
        if (if_valid_i && dec_cnt_i) begin
            dec_id_d = 1'b1;
        end else if (id_valid_i || flush_i || cnt_we_i) begin
            dec_id_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            start_q  <= '0;
            end_q    <= '0;
            cnt_q    <= '0;
            dec_id_q <= 1'b0;
        end else begin
            start_q  <= start_d;
            end_q    <= end_d;
            cnt_q    <= cnt_d;
            dec_id_q <= dec_id_d;
        end
    end

    // Outputs straight from the registers; the counter is zero-extended.
    always_comb begin
        regs_o                       = '0;
        regs_o.start_addr            = start_q;
        regs_o.end_addr              = end_q;
        regs_o.counter[CNT_W-1:0]    = cnt_q;
        dec_id_o                     = dec_id_q;
        active_o                     = (cnt_q != '0);
    end

`ifdef RISCV_HWLP_PERF_EN
    // Only decrements that actually change the counter are reported.
    assign commit_o = commit && !cnt_we_i && (cnt_q != '0);
`endif

endmodule

// File: rtl/riscv_hwloop_regs_track.sv
// Hardware-loop register bank feeding the hwloop controller. Instantiates one
// lane per loop and fans out the shared write data.
// Optional macro RISCV_HWLP_PERF_EN adds hwlp_iter_o, a saturating count of
// committed decrements across all loops.
module riscv_hwloop_regs_track
    import riscv_hwloop_pkg::*;
#(
    parameter int unsigned N_REGS = HWLP_N_REGS_DEFAULT,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            hwlp_start_data_i,
    input  logic [31:0]            hwlp_end_data_i,
    input  logic [31:0]            hwlp_cnt_data_i,
    input  logic [N_REGS-1:0]      hwlp_start_we_i,
    input  logic [N_REGS-1:0]      hwlp_end_we_i,
    input  logic [N_REGS-1:0]      hwlp_cnt_we_i,
    input  logic [N_REGS-1:0]      hwlp_dec_cnt_i,
    input  logic                   if_valid_i,
    input  logic                   id_valid_i,
    input  logic                   flush_i,
    output logic [N_REGS-1:0][31:0] hwlp_start_addr_o,
    output logic [N_REGS-1:0][31:0] hwlp_end_addr_o,
    output logic [N_REGS-1:0][31:0] hwlp_counter_o,
    output logic [N_REGS-1:0]      hwlp_dec_cnt_id_o,
    output logic [N_REGS-1:0]      hwlp_active_o
`ifdef RISCV_HWLP_PERF_EN
    ,
    output logic [31:0]            hwlp_iter_o
`endif
);

    hwlp_regs_t             lane_regs [N_REGS];
`ifdef RISCV_HWLP_PERF_EN
    logic [N_REGS-1:0]      lane_commit;
`endif

    for (genvar i = 0; i < N_REGS; i++) begin : g_lane
        riscv_hwloop_lane #(
            .CNT_W (CNT_W)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .start_data_i (hwlp_start_data_i),
            .end_data_i   (hwlp_end_data_i),
            .cnt_data_i   (hwlp_cnt_data_i),
            .start_we_i   (hwlp_start_we_i[i]),
            .end_we_i     (hwlp_end_we_i[i]),
            .cnt_we_i     (hwlp_cnt_we_i[i]),
            .dec_cnt_i    (hwlp_dec_cnt_i[i]),
            .if_valid_i   (if_valid_i),
            .id_valid_i   (id_valid_i),
            .flush_i      (flush_i),
            .regs_o       (lane_regs[i]),
            .dec_id_o     (hwlp_dec_cnt_id_o[i]),
            .active_o     (hwlp_active_o[i])
`ifdef RISCV_HWLP_PERF_EN
            ,
            .commit_o     (lane_commit[i])
`endif
        );

        assign hwlp_start_addr_o[i] = lane_regs[i].start_addr;
        assign hwlp_end_addr_o[i]   = lane_regs[i].end_addr;
        assign hwlp_counter_o[i]    = lane_regs[i].counter;
    end

`ifdef RISCV_HWLP_PERF_EN
    logic [31:0] iter_q, iter_d;

    // Add each lane's commit, holding at all-ones instead of wrapping.
    always_comb begin
        iter_d = iter_q;
        for (int i = 0; i < N_REGS; i++) begin
            if (lane_commit[i] && (iter_d != '1)) begin
                iter_d = iter_d + 32'd1;
            end
        end
    end

    // Iteration counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_q <= '0;
        end else begin
            iter_q <= iter_d;
        end
    end

    assign hwlp_iter_o = iter_q;
`else
    // Default build: no iteration counter.
`endif

endmodule

// File: tb/tb_riscv_hwloop_regs_track.sv
// Directed, table-driven bench for riscv_hwloop_regs_track (N_REGS=2, CNT_W=32).
module tb_riscv_hwloop_regs_track;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      start_data, end_data, cnt_data;
    logic [1:0]       start_we, end_we, cnt_we, dec_cnt;
    logic             if_valid, id_valid, flush;
    logic [1:0][31:0] start_addr, end_addr, counter;
    logic [1:0]       dec_id, active;
`ifdef RISCV_HWLP_PERF_EN
    logic [31:0]      iter;
`endif

    int total = 0;
    int bad   = 0;

    riscv_hwloop_regs_track #(
        .N_REGS (2),
        .CNT_W  (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .hwlp_start_data_i (start_data),
        .hwlp_end_data_i   (end_data),
        .hwlp_cnt_data_i   (cnt_data),
        .hwlp_start_we_i   (start_we),
        .hwlp_end_we_i     (end_we),
        .hwlp_cnt_we_i     (cnt_we),
        .hwlp_dec_cnt_i    (dec_cnt),
        .if_valid_i        (if_valid),
        .id_valid_i        (id_valid),
        .flush_i           (flush),
        .hwlp_start_addr_o (start_addr),
        .hwlp_end_addr_o   (end_addr),
        .hwlp_counter_o    (counter),
        .hwlp_dec_cnt_id_o (dec_id),
        .hwlp_active_o     (active)
`ifdef RISCV_HWLP_PERF_EN
        ,
        .hwlp_iter_o       (iter)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  swe, ewe, cwe, dec;
        logic        ifv, idv, fl;
        logic [31:0] sd, ed, cd;
        logic [31:0] e_s0, e_e0, e_c0, e_c1;
        logic [1:0]  e_dec, e_act;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic r,
                       input logic [1:0] swe, input logic [1:0] ewe, input logic [1:0] cwe,
                       input logic [31:0] sd, input logic [31:0] ed, input logic [31:0] cd,
                       input logic [1:0] dec, input logic ifv, input logic idv, input logic fl,
                       input logic [31:0] es0, input logic [31:0] ee0,
                       input logic [31:0] ec0, input logic [31:0] ec1,
                       input logic [1:0] edec, input logic [1:0] eact);
        vec_t v;
        v.name = nm; v.rst = r; v.swe = swe; v.ewe = ewe; v.cwe = cwe;
        v.sd = sd; v.ed = ed; v.cd = cd; v.dec = dec; v.ifv = ifv; v.idv = idv; v.fl = fl;
        v.e_s0 = es0; v.e_e0 = ee0; v.e_c0 = ec0; v.e_c1 = ec1; v.e_dec = edec; v.e_act = eact;
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; start_we = v.swe; end_we = v.ewe; cnt_we = v.cwe;
        start_data = v.sd; end_data = v.ed; cnt_data = v.cd;
        dec_cnt = v.dec; if_valid = v.ifv; id_valid = v.idv; flush = v.fl;
        @(posedge clk);
        #1;
        check({v.name, ".start0"}, start_addr[0], v.e_s0);
        check({v.name, ".end0"},   end_addr[0],   v.e_e0);
        check({v.name, ".cnt0"},   counter[0],    v.e_c0);
        check({v.name, ".cnt1"},   counter[1],    v.e_c1);
        check({v.name, ".dec_id"}, {30'd0, dec_id}, {30'd0, v.e_dec});
        check({v.name, ".active"}, {30'd0, active}, {30'd0, v.e_act});
    endtask

    initial begin
        rst = 1'b1; start_we = '0; end_we = '0; cnt_we = '0; dec_cnt = '0;
        if_valid = 1'b0; id_valid = 1'b0; flush = 1'b0;
        start_data = '0; end_data = '0; cnt_data = '0;

        //   name        rst swe    ewe    cwe    sdata  edata  cdata  dec    ifv idv fl   s0     e0     c0 c1 dec    act
        add("reset",     1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b00, 0, 0, 0,  32'h0,   32'h0,   0, 0, 2'b00, 2'b00);
        add("wr_all0",   0, 2'b01, 2'b01, 2'b01, 32'h100, 32'h120, 32'd3, 2'b00, 0, 0, 0, 32'h100, 32'h120, 3, 0, 2'b00, 2'b01);
        add("fetch_dec", 0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b01, 1, 0, 0,  32'h100, 32'h120, 3, 0, 2'b01, 2'b01);
        add("retire",    0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b00, 0, 1, 0,  32'h100, 32'h120, 2, 0, 2'b00, 2'b01);
        add("fetch2",    0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b01, 1, 0, 0,  32'h100, 32'h120, 2, 0, 2'b01, 2'b01);
        add("b2b",       0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b01, 1, 1, 0,  32'h100, 32'h120, 1, 0, 2'b01, 2'b01);
        add("retire_z",  0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b00, 0, 1, 0,  32'h100, 32'h120, 0, 0, 2'b00, 2'b00);
        add("wr_cnt3",   0, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0, 32'd3, 2'b00, 0, 0, 0,  32'h100, 32'h120, 3, 0, 2'b00, 2'b01);
        add("fetch_f",   0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b01, 1, 0, 0,  32'h100, 32'h120, 3, 0, 2'b01, 2'b01);
        add("flush",     0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b00, 0, 1, 1,  32'h100, 32'h120, 3, 0, 2'b00, 2'b01);
        add("no_ifv",    0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b01, 0, 1, 0,  32'h100, 32'h120, 3, 0, 2'b00, 2'b01);
        add("wr_cnt0",   0, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0, 32'd0, 2'b00, 0, 0, 0,  32'h100, 32'h120, 0, 0, 2'b00, 2'b00);
        add("fetch_z",   0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b01, 1, 0, 0,  32'h100, 32'h120, 0, 0, 2'b01, 2'b00);
        add("sat_zero",  0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b00, 0, 1, 0,  32'h100, 32'h120, 0, 0, 2'b00, 2'b00);
        add("wr_c1_5",   0, 2'b00, 2'b00, 2'b10, 32'h0, 32'h0, 32'd5, 2'b00, 0, 0, 0,  32'h100, 32'h120, 0, 5, 2'b00, 2'b10);
        add("fetch_l1",  0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b10, 1, 0, 0,  32'h100, 32'h120, 0, 5, 2'b10, 2'b10);
        add("wr_vs_cmt", 0, 2'b00, 2'b00, 2'b10, 32'h0, 32'h0, 32'd7, 2'b00, 0, 1, 0,  32'h100, 32'h120, 0, 7, 2'b00, 2'b10);
        add("fetch_l1b", 0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b10, 1, 0, 0,  32'h100, 32'h120, 0, 7, 2'b10, 2'b10);
        add("wr_clears", 0, 2'b00, 2'b00, 2'b10, 32'h0, 32'h0, 32'd5, 2'b00, 0, 0, 0,  32'h100, 32'h120, 0, 5, 2'b00, 2'b10);
        add("fetch_l1c", 0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b10, 1, 0, 0,  32'h100, 32'h120, 0, 5, 2'b10, 2'b10);
        add("rst_mid",   1, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0, 32'd9, 2'b00, 0, 0, 0,  32'h0,   32'h0,   0, 0, 2'b00, 2'b00);
        add("no_ghost",  0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b00, 0, 1, 0,  32'h0,   32'h0,   0, 0, 2'b00, 2'b00);
        add("wr_both",   0, 2'b00, 2'b00, 2'b11, 32'h0, 32'h0, 32'd2, 2'b00, 0, 0, 0,  32'h0,   32'h0,   2, 2, 2'b00, 2'b11);
        add("fetch_11",  0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b11, 1, 0, 0,  32'h0,   32'h0,   2, 2, 2'b11, 2'b11);
        add("retire_11", 0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 2'b00, 0, 1, 0,  32'h0,   32'h0,   1, 1, 2'b00, 2'b11);
        add("wr_start",  0, 2'b01, 2'b00, 2'b00, 32'h200, 32'h0, 32'd0, 2'b00, 0, 0, 0, 32'h200, 32'h0,   1, 1, 2'b00, 2'b11);

        foreach (vecs[k]) apply(vecs[k]);

`ifdef RISCV_HWLP_PERF_EN
        // Since the mid-run reset, only the two commits of retire_11 count.
        check("iter_after_rst", iter, 32'd2);
`endif

        // Hand sequence: flush without retire still discards the in-flight decrement.
        @(negedge clk);
        start_we = '0; end_we = '0; cnt_we = '0; start_data = '0;
        dec_cnt = 2'b01; if_valid = 1'b1; id_valid = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        check("seq.flush_set", {30'd0, dec_id}, 32'd1);
        @(negedge clk);
        dec_cnt = 2'b00; if_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        check("seq.flush_clr", {30'd0, dec_id}, 32'd0);
        check("seq.flush_cnt", counter[0], 32'd1);
        @(negedge clk);
        flush = 1'b0; id_valid = 1'b1;
        @(posedge clk); #1;
        check("seq.no_commit", counter[0], 32'd1);

        // Hand sequence: reset while a loop-1 decrement is pending.
        @(negedge clk);
        id_valid = 1'b0; dec_cnt = 2'b10; if_valid = 1'b1;
        @(posedge clk); #1;
        check("seq.pend_l1", {30'd0, dec_id}, 32'd2);
        @(negedge clk);
        rst = 1'b1; dec_cnt = 2'b00; if_valid = 1'b0; id_valid = 1'b1;
        @(posedge clk); #1;
        check("seq.rst_cnt1", counter[1], 32'd0);
        check("seq.rst_dec",  {30'd0, dec_id}, 32'd0);
        check("seq.rst_start", start_addr[0], 32'd0);
`ifdef RISCV_HWLP_PERF_EN
        check("seq.rst_iter", iter, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0; id_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
